fixed_point_alu_arbiter: RTL and testbench
==========================================

Name: fixed_point_alu_arbiter

Overview:
- Shares one fixed-point add/subtract datapath between NUM_REQ requesters using round-robin arbitration.
- Each requester presents an operand pair and an add/sub select over a valid/ready handshake.
- The block returns one registered result per accepted operation, tagged with the requester index, an overflow flag and optional saturation.
- Sits between the shading/interpolation units and the shared arithmetic resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..16).
- SATURATE, 0, 1 = clamp overflowed results to MAX/MIN; 0 = wrap.
- ID_W, $clog2(NUM_REQ), width of the requester tag.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- req_valid  input  NUM_REQ  per-requester operation valid
- req_ready  output  NUM_REQ  per-requester accept; one-hot or zero
- req_op1  input  NUM_REQ x fixed_point::fixed_point_t  first operand per requester
- req_op2  input  NUM_REQ x fixed_point::fixed_point_t  second operand per requester
- req_sub  input  NUM_REQ  1 = op1-op2, 0 = op1+op2
- resp_valid  output  1  result register holds a valid result
- resp_ready  input  1  downstream accepts result
- resp_id  output  ID_W  index of requester that issued the result
- resp_result  output  fixed_point::fixed_point_t  result, W = $bits(fixed_point_t)
- resp_overflow  output  1  signed overflow occurred (before any saturation)

Behaviour:
- Reset (async assert, sync release): resp_valid=0, resp_id=0, resp_result=0, resp_overflow=0, RR pointer=0. req_ready is combinational and therefore 0 while resp_valid=0 is not the cause; after reset it follows the rules below.
- Output slot is free when resp_valid=0 or (resp_valid & resp_ready).
- Grant is combinational:
  - When the slot is free, select the first asserted req_valid starting at index ptr, wrapping modulo NUM_REQ.
  - Assert req_ready only for that index.
  - If the slot is not free, all req_ready=0.
- Accept occurs when req_valid[i] & req_ready[i]. On the next edge:
  - resp_valid=1, resp_id=i, and the result/overflow are registered.
  - ptr = (i+1) mod NUM_REQ.
  - Latency is 1 cycle accept→resp_valid.
  - Throughput is 1 op per cycle when resp_ready is held high.
- If no accept occurs and resp_ready is asserted with resp_valid set, then resp_valid→0 and ptr is unchanged.
- Holding: while resp_valid & !resp_ready, the resp_* outputs are held stable.
- Arithmetic: W-bit two's complement, with sum/diff truncated to W bits.
  - add overflow = (s1==s2) & (sr!=s1)
  - sub overflow = (s1!=s2) & (sr==s2)
  - s1, s2, sr are the MSBs of op1, op2 and the raw result.
- Saturation when SATURATE=1 and overflow: result = MAX (0111…1) if s1=0, else MIN (1000…0). resp_overflow still reports 1.
- Requesters must hold their op/sub/valid stable until accepted. A requester may drop valid before it is accepted; it is simply not granted.
- Any reset assertion mid-operation discards the pending result; no response is emitted for it.
- NUM_REQ=1 degenerates to a registered ALU with a skid-free handshake; ptr stays 0.

Test Plan:
- Single op: req0 op1=3, op2=5, sub=0, resp_ready=1 → next cycle resp_valid=1, id=0, result=8, ovf=0. The cycle after that, resp_valid=0.
- Round-robin fairness: all 4 requesters valid continuously, resp_ready=1 → grant order 0,1,2,3,0,1… with one result per cycle. Then requester 2 only → granted immediately regardless of ptr.
- Overflow, SATURATE=0: op1=MAX, op2=1, add → result=MIN, ovf=1. op1=MIN, op2=1, sub → result=MAX, ovf=1.
- Overflow, SATURATE=1: same stimuli → results MAX and MIN respectively, ovf=1. op1=-2, op2=-3, sub → result=1, ovf=0.
- Backpressure: resp_ready=0 for 3 cycles with req1 and req3 valid → one result held stable and all req_ready=0. resp_ready=1 → the held result is consumed, the next grant occurs in the same cycle, and the following result appears one cycle later.
- Reset mid-op: accept req2, assert rst_n=0 before resp_ready → resp_valid=0 immediately (async). After release, the first grant with all valid is 0.

Source files
------------

// File: rtl/fixed_point_pkg.sv
// Fixed-point number format shared by the interpolation/shading datapaths.
// fixed_point_t is a signed Q8.8 value; FP_MAX/FP_MIN are its saturation limits.
package fixed_point;

    localparam int unsigned W      = 16;
    localparam int unsigned FRAC_W = 8;

    typedef logic signed [W-1:0] fixed_point_t;

    localparam fixed_point_t FP_MAX = {1'b0, {(W-1){1'b1}}};
    localparam fixed_point_t FP_MIN = {1'b1, {(W-1){1'b0}}};

endpackage

// File: rtl/fixed_point_alu_arbiter_if.sv
// Request/response bundle between NUM_REQ requesters and the shared ALU.
//   master : requester/consumer side (drives operands, valid, resp_ready)
//   slave  : ALU arbiter side (drives req_ready and the resp_* result)
interface fixed_point_alu_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);

    logic [NUM_REQ-1:0]                       req_valid;
    logic [NUM_REQ-1:0]                       req_ready;
    fixed_point::fixed_point_t [NUM_REQ-1:0]  req_op1;
    fixed_point::fixed_point_t [NUM_REQ-1:0]  req_op2;
    logic [NUM_REQ-1:0]                       req_sub;

    logic                                     resp_valid;
    logic                                     resp_ready;
    logic [ID_W-1:0]                          resp_id;
    fixed_point::fixed_point_t                resp_result;
    logic                                     resp_overflow;

    modport master (
        output req_valid, req_op1, req_op2, req_sub, resp_ready,
        input  req_ready, resp_valid, resp_id, resp_result, resp_overflow
    );

    modport slave (
        input  req_valid, req_op1, req_op2, req_sub, resp_ready,
        output req_ready, resp_valid, resp_id, resp_result, resp_overflow
    );

endinterface

// File: rtl/fixed_point_alu_arbiter.sv
// Round-robin shared fixed-point add/subtract unit.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : slave side of fixed_point_alu_arbiter_if
//                req_valid/req_ready/req_op1/req_op2/req_sub per requester,
//                resp_valid/resp_ready/resp_id/resp_result/resp_overflow result slot.
// req_ready is combinational (grant of the current cycle); all resp_* are registered.
module fixed_point_alu_arbiter
    import fixed_point::*;
#(
    parameter int unsigned NUM_REQ  = 4,
    parameter int unsigned SATURATE = 0,
    parameter int unsigned ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    fixed_point_alu_arbiter_if.slave   bus
);

    localparam int unsigned     FP_W     = $bits(fixed_point_t);
    localparam logic [ID_W:0]   NUM_REQ_X = (ID_W+1)'(NUM_REQ);
    localparam logic [ID_W-1:0] LAST_IDX  = ID_W'(NUM_REQ - 1);

    logic                 resp_valid_q;
    logic [ID_W-1:0]      resp_id_q;
    fixed_point_t         resp_result_q;
    logic                 resp_overflow_q;
    logic [ID_W-1:0]      ptr_q;

    logic                 slot_free_c;
    logic                 grant_vld_c;
    logic [ID_W-1:0]      grant_idx_c;
    logic [ID_W:0]        cand_c;
    logic                 accept_c;
    logic [NUM_REQ-1:0]   req_ready_c;
    fixed_point_t         op1_c;
    fixed_point_t         op2_c;
    logic                 sub_c;
    fixed_point_t         raw_c;
    logic                 ovf_c;
    fixed_point_t         result_c;
    logic [ID_W-1:0]      ptr_next_c;

    // Slot can take a new result if empty or being drained this cycle.
    assign slot_free_c = !resp_valid_q || bus.resp_ready;

    // Round-robin search: first valid requester at or after ptr, wrapping.
    always_comb begin
        grant_vld_c = 1'b0;
        grant_idx_c = '0;
        cand_c      = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand_c = {1'b0, ptr_q} + (ID_W+1)'(k);
            if (cand_c >= NUM_REQ_X) begin
                cand_c = cand_c - NUM_REQ_X;
            end
            if (!grant_vld_c && bus.req_valid[cand_c[ID_W-1:0]]) begin
                grant_vld_c = 1'b1;
                grant_idx_c = cand_c[ID_W-1:0];
            end
        end
    end

    assign accept_c = slot_free_c && grant_vld_c;

    // One-hot ready for the winner only when the slot can accept.
    always_comb begin
        req_ready_c = '0;
        if (accept_c) begin
            req_ready_c[grant_idx_c] = 1'b1;
        end
    end

    // Shared add/sub datapath on the granted operands.
    always_comb begin
        op1_c    = bus.req_op1[grant_idx_c];
        op2_c    = bus.req_op2[grant_idx_c];
        sub_c    = bus.req_sub[grant_idx_c];
        raw_c    = sub_c ? (op1_c - op2_c) : (op1_c + op2_c);
        // Overflow from sign bits: add needs equal signs flipping, sub needs
        // differing signs with the result taking op2's sign.
        if (sub_c) begin
            ovf_c = (op1_c[FP_W-1] != op2_c[FP_W-1]) && (raw_c[FP_W-1] == op2_c[FP_W-1]);
        end else begin
            ovf_c = (op1_c[FP_W-1] == op2_c[FP_W-1]) && (raw_c[FP_W-1] != op1_c[FP_W-1]);
        end
        result_c = raw_c;
        if ((SATURATE != 0) && ovf_c) begin
            result_c = op1_c[FP_W-1] ? FP_MIN : FP_MAX;
        end
    end

    // Pointer moves just past the winner.
    assign ptr_next_c = (grant_idx_c == LAST_IDX) ? '0 : (grant_idx_c + ID_W'(1));

    // Result slot and round-robin pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resp_valid_q    <= 1'b0;
            resp_id_q       <= '0;
            resp_result_q   <= '0;
            resp_overflow_q <= 1'b0;
            ptr_q           <= '0;
        end else if (accept_c) begin
            resp_valid_q    <= 1'b1;
            resp_id_q       <= grant_idx_c;
            resp_result_q   <= result_c;
            resp_overflow_q <= ovf_c;
            ptr_q           <= ptr_next_c;
        end else if (bus.resp_ready) begin
            resp_valid_q    <= 1'b0;
        end
    end

    assign bus.req_ready     = req_ready_c;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_id       = resp_id_q;
    assign bus.resp_result   = resp_result_q;
    assign bus.resp_overflow = resp_overflow_q;

endmodule

// File: tb/tb_fixed_point_alu_arbiter.sv
// Bench for fixed_point_alu_arbiter: a wrapping and a saturating instance share
// the same stimulus and are compared against an arithmetic/queue-level model.
module tb_fixed_point_alu_arbiter;
    import fixed_point::*;

    localparam int N = 4;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    logic [N-1:0]             valid;
    logic [N-1:0]             sub;
    fixed_point_t [N-1:0]     op1;
    fixed_point_t [N-1:0]     op2;
    logic                     resp_ready;

    fixed_point_alu_arbiter_if #(.NUM_REQ(N), .ID_W(2)) if_w ();
    fixed_point_alu_arbiter_if #(.NUM_REQ(N), .ID_W(2)) if_s ();

    assign if_w.req_valid  = valid;
    assign if_w.req_sub    = sub;
    assign if_w.req_op1    = op1;
    assign if_w.req_op2    = op2;
    assign if_w.resp_ready = resp_ready;
    assign if_s.req_valid  = valid;
    assign if_s.req_sub    = sub;
    assign if_s.req_op1    = op1;
    assign if_s.req_op2    = op2;
    assign if_s.resp_ready = resp_ready;

    fixed_point_alu_arbiter #(.NUM_REQ(N), .SATURATE(0), .ID_W(2)) u_wrap (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_w)
    );

    fixed_point_alu_arbiter #(.NUM_REQ(N), .SATURATE(1), .ID_W(2)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (if_s)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: one result slot plus the fairness pointer.
    logic         m_valid;
    int           m_id;
    fixed_point_t m_w;
    fixed_point_t m_s;
    logic         m_o;
    int           m_ptr;
    int           last_grant;

    typedef struct {
        fixed_point_t op1;
        fixed_point_t op2;
        logic         sub;
        fixed_point_t exp_w;
        fixed_point_t exp_s;
        logic         exp_o;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Integer arithmetic reference: exact result, then range test and clamp.
    task automatic alu(input fixed_point_t a, input fixed_point_t b, input logic s,
                       output fixed_point_t wrap, output fixed_point_t sat, output logic ovf);
        int ia, ib, r, hi, lo;
        ia  = int'(a);
        ib  = int'(b);
        r   = s ? (ia - ib) : (ia + ib);
        hi  = (1 << (W - 1)) - 1;
        lo  = -(1 << (W - 1));
        ovf = (r > hi) || (r < lo);
        wrap = fixed_point_t'(r);
        sat  = ovf ? ((r > 0) ? FP_MAX : FP_MIN) : wrap;
    endtask

    function automatic int model_grant();
        int i;
        if (m_valid && !resp_ready) return -1;
        for (int k = 0; k < N; k++) begin
            i = (m_ptr + k) % N;
            if (valid[i]) return i;
        end
        return -1;
    endfunction

    // One clock: check grant before the edge, advance model, check slot after.
    task automatic step();
        int g;
        fixed_point_t w, s;
        logic o;
        g = model_grant();
        w = '0; s = '0; o = 1'b0;
        #1;
        check("req_ready_wrap", 32'(if_w.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        check("req_ready_sat",  32'(if_s.req_ready), (g >= 0) ? (32'd1 << g) : 32'd0);
        if (g >= 0) alu(op1[g], op2[g], sub[g], w, s, o);
        @(posedge clk);
        if (g >= 0) begin
            m_valid = 1'b1; m_id = g; m_w = w; m_s = s; m_o = o;
            m_ptr = (g + 1) % N;
        end else if (resp_ready) begin
            m_valid = 1'b0;
        end
        last_grant = g;
        #1;
        check("resp_valid_wrap", 32'(if_w.resp_valid), 32'(m_valid));
        check("resp_valid_sat",  32'(if_s.resp_valid), 32'(m_valid));
        if (m_valid) begin
            check("resp_id_wrap", 32'(if_w.resp_id), 32'(m_id));
            check("resp_id_sat",  32'(if_s.resp_id), 32'(m_id));
            check("resp_result_wrap", 32'(if_w.resp_result), 32'(m_w));
            check("resp_result_sat",  32'(if_s.resp_result), 32'(m_s));
            check("resp_ovf_wrap", 32'(if_w.resp_overflow), 32'(m_o));
            check("resp_ovf_sat",  32'(if_s.resp_overflow), 32'(m_o));
        end
        @(negedge clk);
    endtask

    function automatic fixed_point_t rand_fp();
        case ($urandom_range(0, 5))
            0: return FP_MAX;
            1: return FP_MIN;
            2: return '0;
            3: return fixed_point_t'(int'($urandom_range(0, 64)) - 32);
            default: return fixed_point_t'($urandom());
        endcase
    endfunction

    initial begin
        int  held_id;
        fixed_point_t held_res;
        int  other;

        vecs[0] = '{16'sd3,     16'sd5,     1'b0, 16'sd8,     16'sd8,     1'b0};
        vecs[1] = '{FP_MAX,     16'sd1,     1'b0, FP_MIN,     FP_MAX,     1'b1};
        vecs[2] = '{FP_MIN,     16'sd1,     1'b1, FP_MAX,     FP_MIN,     1'b1};
        vecs[3] = '{-16'sd2,    -16'sd3,    1'b1, 16'sd1,     16'sd1,     1'b0};
        vecs[4] = '{FP_MIN,     FP_MIN,     1'b0, 16'sd0,     FP_MIN,     1'b1};
        vecs[5] = '{FP_MAX,     -16'sd1,    1'b1, FP_MIN,     FP_MAX,     1'b1};
        vecs[6] = '{16'sd0,     FP_MIN,     1'b1, FP_MIN,     FP_MAX,     1'b1};
        vecs[7] = '{-16'sd1,    16'sd1,     1'b0, 16'sd0,     16'sd0,     1'b0};

        rst_n = 1'b0;
        valid = '0; sub = '0; op1 = '0; op2 = '0; resp_ready = 1'b0;
        m_valid = 1'b0; m_id = 0; m_w = '0; m_s = '0; m_o = 1'b0; m_ptr = 0;
        last_grant = -1;

        @(negedge clk);
        @(negedge clk);
        check("rst_resp_valid", 32'(if_w.resp_valid), 32'd0);
        check("rst_resp_id", 32'(if_w.resp_id), 32'd0);
        check("rst_resp_result", 32'(if_w.resp_result), 32'd0);
        check("rst_resp_ovf", 32'(if_s.resp_overflow), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Fairness: all requesters valid, one result per cycle in index order.
        valid = 4'hF; resp_ready = 1'b1;
        for (int i = 0; i < N; i++) begin
            op1[i] = fixed_point_t'(i + 1); op2[i] = fixed_point_t'(10 * i); sub[i] = 1'b0;
        end
        for (int k = 0; k < 8; k++) begin
            step();
            check("rr_order", 32'(if_w.resp_id), 32'(k % N));
        end
        valid = 4'b0100;
        step();
        check("rr_lone_req2", 32'(if_w.resp_id), 32'd2);
        valid = '0;
        step();
        check("rr_drain", 32'(if_w.resp_valid), 32'd0);

        // Arithmetic vectors through requester 0.
        for (int i = 0; i < 8; i++) begin
            valid = 4'b0001; op1[0] = vecs[i].op1; op2[0] = vecs[i].op2; sub[0] = vecs[i].sub;
            step();
            check("vec_id", 32'(if_w.resp_id), 32'd0);
            check("vec_result_wrap", 32'(if_w.resp_result), 32'(vecs[i].exp_w));
            check("vec_result_sat", 32'(if_s.resp_result), 32'(vecs[i].exp_s));
            check("vec_ovf", 32'(if_w.resp_overflow), 32'(vecs[i].exp_o));
            valid = '0;
            step();
            check("vec_resp_gone", 32'(if_w.resp_valid), 32'd0);
        end

        // Backpressure with requesters 1 and 3 competing.
        valid = 4'b1010; resp_ready = 1'b0;
        op1[1] = 16'sd100; op2[1] = 16'sd1; sub[1] = 1'b1;
        op1[3] = 16'sd7;   op2[3] = 16'sd9; sub[3] = 1'b0;
        step();
        held_id = last_grant;
        held_res = if_w.resp_result;
        other = (held_id == 1) ? 3 : 1;
        valid[held_id] = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            check("bp_ready_zero", 32'(if_w.req_ready), 32'd0);
            check("bp_hold_id", 32'(if_w.resp_id), 32'(held_id));
            check("bp_hold_result", 32'(if_w.resp_result), 32'(held_res));
        end
        resp_ready = 1'b1;
        step();
        check("bp_next_grant", 32'(if_w.resp_id), 32'(other));
        check("bp_next_valid", 32'(if_w.resp_valid), 32'd1);
        valid = '0;
        step();
        check("bp_drain", 32'(if_w.resp_valid), 32'd0);

        // Reset while a result is pending.
        valid = 4'b0100; resp_ready = 1'b0;
        op1[2] = 16'sd5; op2[2] = 16'sd5; sub[2] = 1'b0;
        step();
        check("rstmid_pending", 32'(if_w.resp_valid), 32'd1);
        valid = '0;
        #2;
        rst_n = 1'b0;
        #1;
        check("rstmid_async_wrap", 32'(if_w.resp_valid), 32'd0);
        check("rstmid_async_sat", 32'(if_s.resp_valid), 32'd0);
        m_valid = 1'b0; m_ptr = 0;
        @(negedge clk);
        rst_n = 1'b1;
        valid = 4'hF; resp_ready = 1'b1;
        step();
        check("rstmid_first_grant", 32'(if_w.resp_id), 32'd0);

        // Randomized traffic against the model.
        valid = '0;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < N; i++) begin
                if (i == last_grant || !valid[i]) begin
                    valid[i] = ($urandom_range(0, 2) != 0);
                    op1[i]   = rand_fp();
                    op2[i]   = rand_fp();
                    sub[i]   = $urandom_range(0, 1) != 0;
                end else if ($urandom_range(0, 15) == 0) begin
                    valid[i] = 1'b0;
                end
            end
            resp_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
